// File: rtl/hc595_frame_decoder_if.sv
// 74HC595 snoop bus: serial inputs from the display driver plus decoded display state.
// The master side drives SCK/SER/RCK and the slave side (decoder) drives the results.
interface hc595_frame_decoder_if;
    logic       sclk_in;
    logic       sdio_in;
    logic       rclk_in;
    logic [3:0] digit0_out;
    logic [3:0] digit1_out;
    logic [3:0] digit2_out;
    logic [3:0] digit3_out;
    logic [3:0] digit4_out;
    logic [3:0] digit5_out;
    logic [5:0] dp_out;
    logic       frame_done_out;
    logic       scan_done_out;
    logic [2:0] err_out;
    logic       stale_out;

    modport master (
        output sclk_in, sdio_in, rclk_in,
        input  digit0_out, digit1_out, digit2_out, digit3_out, digit4_out, digit5_out,
        input  dp_out, frame_done_out, scan_done_out, err_out, stale_out
    );

    modport slave (
        input  sclk_in, sdio_in, rclk_in,
        output digit0_out, digit1_out, digit2_out, digit3_out, digit4_out, digit5_out,
        output dp_out, frame_done_out, scan_done_out, err_out, stale_out
    );
endinterface

// File: rtl/hc595_frame_decoder.sv
// Snoops a 74HC595 7-segment bus and decodes it into six digits.
// Results appear 2 cycles after a synced RCK edge; there is no backpressure, because the bus is observed only.
module hc595_frame_decoder #(
    parameter int TIMEOUT_CYCLES = 1200000,
    parameter int SYNC_STAGES    = 2
) (
    input logic                  clk_in,
    input logic                  rst_in,
    hc595_frame_decoder_if.slave bus
);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] sdio_sync_q, sdio_sync_d;
    logic [SYNC_STAGES-1:0] rclk_sync_q, rclk_sync_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [15:0]            sh_q, sh_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic                   pend_vld_q, pend_vld_d;
    logic                   pend_ferr_q, pend_ferr_d;
    logic [15:0]            pend_word_q, pend_word_d;
    logic [5:0][3:0]        digit_q, digit_d;
    logic [5:0]             dp_q, dp_d;
    logic [5:0]             valid_q, valid_d;
    logic                   frame_done_q, frame_done_d;
    logic                   scan_done_q, scan_done_d;
    logic [2:0]             err_q, err_d;
    logic [IDLE_W-1:0]      idle_q, idle_d;
    logic                   stale_q, stale_d;

    logic       armed, sclk_rise, rclk_rise;
    logic [4:0] cnt_inc, cnt_eval;
    logic [7:0] seg, sel;
    logic [2:0] pos;
    logic       sel_ok, seg_bad;
    logic [3:0] dec;
    logic [5:0] valid_nxt;

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk_in};
        sdio_sync_d  = {sdio_sync_q[SYNC_STAGES-2:0], bus.sdio_in};
        rclk_sync_d  = {rclk_sync_q[SYNC_STAGES-2:0], bus.rclk_in};
        fill_d       = fill_q;
        sh_d         = sh_q;
        bit_cnt_d    = bit_cnt_q;
        pend_vld_d   = 1'b0;
        pend_ferr_d  = 1'b0;
        pend_word_d  = pend_word_q;
        digit_d      = digit_q;
        dp_d         = dp_q;
        valid_d      = valid_q;
        frame_done_d = 1'b0;
        scan_done_d  = 1'b0;
        err_d        = 3'b000;
        idle_d       = idle_q;
        valid_nxt    = valid_q;

        // Edges are masked until the synchronizers have refilled after reset.
        armed = (fill_q == FILL_W'(SYNC_STAGES));
        if (!armed) fill_d = fill_q + 1'b1;
        sclk_rise = armed && sclk_sync_q[SYNC_STAGES-2] && !sclk_sync_q[SYNC_STAGES-1];
        rclk_rise = armed && rclk_sync_q[SYNC_STAGES-2] && !rclk_sync_q[SYNC_STAGES-1];

        cnt_inc  = (bit_cnt_q == 5'd17) ? 5'd17 : bit_cnt_q + 5'd1;
        cnt_eval = sclk_rise ? cnt_inc : bit_cnt_q;
        if (sclk_rise) begin
            sh_d      = {sh_q[14:0], sdio_sync_q[SYNC_STAGES-1]};
            bit_cnt_d = cnt_inc;
        end
        if (rclk_rise) begin
            bit_cnt_d = 5'd0;
            if (cnt_eval == 5'd16) begin
                pend_vld_d  = 1'b1;
                pend_word_d = sh_d;
            end else begin
                pend_ferr_d = 1'b1;
            end
        end

        seg    = pend_word_q[15:8];
        sel    = pend_word_q[7:0];
        sel_ok = 1'b1;
        case (sel)
            8'hFE:   pos = 3'd0;
            8'hFD:   pos = 3'd1;
            8'hFB:   pos = 3'd2;
            8'hF7:   pos = 3'd3;
            8'hEF:   pos = 3'd4;
            8'hDF:   pos = 3'd5;
            default: begin pos = 3'd0; sel_ok = 1'b0; end
        endcase

        seg_bad = 1'b0;
        case (seg[6:0])
            7'h3F:   dec = 4'd0;
            7'h06:   dec = 4'd1;
            7'h5B:   dec = 4'd2;
            7'h4F:   dec = 4'd3;
            7'h66:   dec = 4'd4;
            7'h6D:   dec = 4'd5;
            7'h7D:   dec = 4'd6;
            7'h07:   dec = 4'd7;
            7'h7F:   dec = 4'd8;
            7'h6F:   dec = 4'd9;
            7'h00:   dec = 4'hF;
            default: begin dec = 4'hE; seg_bad = 1'b1; end
        endcase

        err_d[0] = pend_ferr_q;
        if (pend_vld_q) begin
            if (!sel_ok) begin
                err_d[1] = 1'b1;
            end else begin
                digit_d[pos] = dec;
                dp_d[pos]    = seg[7];
                err_d[2]     = seg_bad;
                frame_done_d = 1'b1;
                valid_nxt    = valid_q | (6'b000001 << pos);
                if (valid_nxt == 6'h3F) begin
                    scan_done_d = 1'b1;
                    valid_d     = 6'h00;
                end else begin
                    valid_d = valid_nxt;
                end
            end
        end

        // Only fully accepted frames count as activity.
        if (frame_done_d)                            idle_d = '0;
        else if (idle_q != IDLE_W'(TIMEOUT_CYCLES)) idle_d = idle_q + 1'b1;
        stale_d = !frame_done_d && (idle_d == IDLE_W'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sclk_sync_q  <= '0;
            sdio_sync_q  <= '0;
            rclk_sync_q  <= '0;
            fill_q       <= '0;
            sh_q         <= '0;
            bit_cnt_q    <= '0;
            pend_vld_q   <= 1'b0;
            pend_ferr_q  <= 1'b0;
            pend_word_q  <= '0;
            digit_q      <= {6{4'hF}};
            dp_q         <= '0;
            valid_q      <= '0;
            frame_done_q <= 1'b0;
            scan_done_q  <= 1'b0;
            err_q        <= '0;
            idle_q       <= '0;
            stale_q      <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            sdio_sync_q  <= sdio_sync_d;
            rclk_sync_q  <= rclk_sync_d;
            fill_q       <= fill_d;
            sh_q         <= sh_d;
            bit_cnt_q    <= bit_cnt_d;
            pend_vld_q   <= pend_vld_d;
            pend_ferr_q  <= pend_ferr_d;
            pend_word_q  <= pend_word_d;
            digit_q      <= digit_d;
            dp_q         <= dp_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            scan_done_q  <= scan_done_d;
            err_q        <= err_d;
            idle_q       <= idle_d;
            stale_q      <= stale_d;
        end
    end

    assign bus.digit0_out     = digit_q[0];
    assign bus.digit1_out     = digit_q[1];
    assign bus.digit2_out     = digit_q[2];
    assign bus.digit3_out     = digit_q[3];
    assign bus.digit4_out     = digit_q[4];
    assign bus.digit5_out     = digit_q[5];
    assign bus.dp_out         = dp_q;
    assign bus.frame_done_out = frame_done_q;
    assign bus.scan_done_out  = scan_done_q;
    assign bus.err_out        = err_q;
    assign bus.stale_out      = stale_q;
endmodule

// File: tb/tb_hc595_frame_decoder.sv
// Directed bench for hc595_frame_decoder: bit-banged 74HC595 frames with hand-computed expectations.
module tb_hc595_frame_decoder;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    hc595_frame_decoder_if bus ();

    hc595_frame_decoder #(
        .TIMEOUT_CYCLES(100),
        .SYNC_STAGES   (2)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    int fd_cnt, fd_cyc, fd_stale, scan_cnt;
    logic [2:0] err_acc;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic send_bits(input logic [16:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.sdio_in = w[i];
            tick(2);
            bus.sclk_in = 1'b1;
            tick(2);
            bus.sclk_in = 1'b0;
        end
    endtask

    // Raises RCK (optionally with SCK) and records the response over the next 8 cycles.
    task automatic pulse_rclk(input bit with_sclk);
        fd_cnt   = 0;
        fd_cyc   = 0;
        fd_stale = 0;
        scan_cnt = 0;
        err_acc  = 3'b000;
        bus.rclk_in = 1'b1;
        if (with_sclk) bus.sclk_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            if (i == 3) begin
                bus.rclk_in = 1'b0;
                bus.sclk_in = 1'b0;
            end
            if (bus.frame_done_out) begin
                fd_cnt++;
                fd_cyc   = i;
                fd_stale = int'(bus.stale_out);
            end
            if (bus.scan_done_out) scan_cnt++;
            err_acc = err_acc | bus.err_out;
        end
    endtask

    task automatic send_frame(input logic [15:0] w);
        send_bits({1'b0, w}, 16);
        tick(1);
        pulse_rclk(1'b0);
    endtask

    task automatic send_coinc(input logic [15:0] w);
        send_bits({2'b00, w[15:1]}, 15);
        bus.sdio_in = w[0];
        tick(2);
        pulse_rclk(1'b1);
    endtask

    logic [15:0] scan_words [6];
    int scan_total, scan_last;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        scan_words[0] = 16'h3FFE;
        scan_words[1] = 16'h86FD;
        scan_words[2] = 16'h5BFB;
        scan_words[3] = 16'hCFF7;
        scan_words[4] = 16'h66EF;
        scan_words[5] = 16'h6DDF;
        bus.sclk_in = 1'b0;
        bus.sdio_in = 1'b0;
        bus.rclk_in = 1'b0;
        rst_in = 1'b1;
        tick(3);
        check("rst_digit0", bus.digit0_out, 4'hF);
        check("rst_digit5", bus.digit5_out, 4'hF);
        check("rst_dp", bus.dp_out, 0);
        check("rst_frame_done", bus.frame_done_out, 0);
        check("rst_err", bus.err_out, 0);
        check("rst_stale", bus.stale_out, 0);
        rst_in = 1'b0;
        tick(4);

        send_frame(16'h06FE);
        check("f1_digit0", bus.digit0_out, 1);
        check("f1_dp0", bus.dp_out[0], 0);
        check("f1_done_cnt", fd_cnt, 1);
        check("f1_done_latency", fd_cyc, 3);
        check("f1_err", err_acc, 0);

        scan_total = 0;
        scan_last  = 0;
        for (int k = 0; k < 6; k++) begin
            send_frame(scan_words[k]);
            scan_total += scan_cnt;
            if (k == 5) scan_last = scan_cnt;
        end
        check("scan_digit0", bus.digit0_out, 0);
        check("scan_digit1", bus.digit1_out, 1);
        check("scan_digit2", bus.digit2_out, 2);
        check("scan_digit3", bus.digit3_out, 3);
        check("scan_digit4", bus.digit4_out, 4);
        check("scan_digit5", bus.digit5_out, 5);
        check("scan_dp", bus.dp_out, 6'b001010);
        check("scan_total", scan_total, 1);
        check("scan_on_sixth", scan_last, 1);

        send_bits(17'h006FE, 15);
        tick(1);
        pulse_rclk(1'b0);
        check("b15_err", err_acc, 3'b001);
        check("b15_done", fd_cnt, 0);
        check("b15_digit0", bus.digit0_out, 0);
        check("b15_dp", bus.dp_out, 6'b001010);

        send_bits(17'h106FE, 17);
        tick(1);
        pulse_rclk(1'b0);
        check("b17_err", err_acc, 3'b001);
        check("b17_done", fd_cnt, 0);
        check("b17_digit0", bus.digit0_out, 0);

        send_frame(16'h12FE);
        check("seg_err_digit0", bus.digit0_out, 4'hE);
        check("seg_err_err", err_acc, 3'b100);
        check("seg_err_done", fd_cnt, 1);

        send_frame(16'h06FC);
        check("sel_err_err", err_acc, 3'b010);
        check("sel_err_done", fd_cnt, 0);
        check("sel_err_digit0", bus.digit0_out, 4'hE);
        check("sel_err_digit1", bus.digit1_out, 1);

        send_coinc(16'h07F7);
        check("coinc_digit3", bus.digit3_out, 7);
        check("coinc_done", fd_cnt, 1);
        check("coinc_err", err_acc, 0);

        send_bits(17'h000A5, 8);
        rst_in = 1'b1;
        tick(2);
        rst_in = 1'b0;
        tick(4);
        check("mid_rst_digit3", bus.digit3_out, 4'hF);
        pulse_rclk(1'b0);
        check("mid_rst_rclk_err", err_acc, 3'b001);
        check("mid_rst_rclk_done", fd_cnt, 0);
        send_frame(16'h6DFE);
        check("mid_rst_digit0", bus.digit0_out, 5);
        check("mid_rst_done", fd_cnt, 1);
        check("mid_rst_err", err_acc, 0);

        check("stale_after_frame", bus.stale_out, 0);
        tick(50);
        check("stale_at_55", bus.stale_out, 0);
        tick(60);
        check("stale_timeout", bus.stale_out, 1);
        send_bits(17'h006FE, 15);
        tick(1);
        pulse_rclk(1'b0);
        check("stale_keep_ferr", bus.stale_out, 1);
        send_frame(16'h06FC);
        check("stale_keep_selerr", bus.stale_out, 1);
        send_frame(16'h4FEF);
        check("stale_clear_done", fd_cnt, 1);
        check("stale_clear_at_done", fd_stale, 0);
        check("stale_clear", bus.stale_out, 0);
        check("stale_clear_digit4", bus.digit4_out, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/hc595_frame_decoder.md
HC595_FRAME_DECODER -- requirements
Module: hc595_frame_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1200000, the clk_in cycles without an accepted frame before stale_out asserts (100 ms at 12 MHz).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth on sclk_in/sdio_in/rclk_in (legal 2..3).
REQ-003 SHALL have clk_in, input, 1: single 12 MHz clock; all logic on its rising edge.
REQ-004 SHALL have rst_in, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have sclk_in, input, 1: 74HC595 shift clock (SCK) from the display driver, asynchronous.
REQ-006 SHALL have sdio_in, input, 1: 74HC595 serial data (SER), MSB first, asynchronous.
REQ-007 SHALL have rclk_in, input, 1: 74HC595 storage clock (RCK), asynchronous.
REQ-008 SHALL have digit0_out..digit5_out, output, 4 each: decoded digit per position (0-9; 4'hF blank; 4'hE undecodable).
REQ-009 SHALL have dp_out, output, 6: decimal-point state per position.
REQ-010 SHALL have frame_done_out, output, 1: one-cycle pulse per accepted frame.
REQ-011 SHALL have scan_done_out, output, 1: one-cycle pulse when all six positions are written since the last pulse.
REQ-012 SHALL have err_out, output, 3: one-cycle pulses {seg_err, sel_err, frame_err}.
REQ-013 SHALL have stale_out, output, 1: level, no accepted frame within TIMEOUT_CYCLES.

Function
REQ-014 SHALL pass sclk_in, sdio_in and rclk_in through SYNC_STAGES flops each and detect rising edges from the last two stages.
REQ-015 SHALL, on an sclk rising edge, shift sh[15:0] <= {sh[14:0], sdio_sync} and increment bit_cnt (5 bits), saturating at 17.
REQ-016 SHALL, on an rclk rising edge, accept the frame only if bit_cnt == 16, then clear bit_cnt in all cases.
REQ-017 SHALL, on an rclk edge with bit_cnt != 16, pulse frame_err for 1 cycle and leave digits, dp_out and valid mask unchanged.
REQ-018 SHALL, when sclk and rclk edges coincide in one cycle, apply the shift first and evaluate bit_cnt+1 for acceptance.
REQ-019 SHALL split an accepted word as seg = sh[15:8] and sel = sh[7:0].
REQ-020 SHALL require sel[7:6] == 2'b11 and exactly one zero in sel[5:0]; position = index of that zero (8'hFE->0 ... 8'hDF->5).
REQ-021 SHALL, on an illegal sel, pulse sel_err and discard the frame without updating any output except err_out.
REQ-022 SHALL decode seg[6:0]: 3F,06,5B,4F,66,6D,7D,07,7F,6F -> 0..9; 00 -> 4'hF; any other -> 4'hE plus a seg_err pulse (frame still written).
REQ-023 SHALL write the decoded digit and dp = seg[7] to the selected position.
REQ-024 SHALL update outputs and pulse frame_done_out exactly 2 clk_in cycles after the synchronized rclk edge is detected.
REQ-025 SHALL set valid[position] per accepted frame and, when valid becomes 6'h3F, pulse scan_done_out in the same cycle as frame_done_out and clear valid.
REQ-026 SHALL count idle cycles (saturating), clear the count on each accepted frame, assert stale_out at count == TIMEOUT_CYCLES, and deassert it with the next frame_done_out.
REQ-027 SHALL not let rejected frames (frame_err, sel_err) clear the idle count.

Reset
REQ-028 SHALL, while rst_in is high at a clk_in edge, clear the synchronizers, sh, bit_cnt, valid and the idle count to 0, set all digitN_out to 4'hF, dp_out to 0, frame_done_out, scan_done_out, err_out and stale_out to 0.
REQ-029 SHALL, when reset is asserted mid-frame, discard the partial frame; the first rclk after release with bit_cnt != 16 raises frame_err only.
REQ-030 SHALL ignore sclk/rclk edges for the SYNC_STAGES cycles after reset release (synchronizers refilling).

Verification
REQ-031 SHALL check: 16 bits of 16'h06FE then rclk -> digit0_out=1, dp_out[0]=0, frame_done_out pulse 2 cycles after the synced edge.
REQ-032 SHALL check: six frames 3F FE, 86 FD, 5B FB, CF F7, 66 EF, 6D DF -> digits 0,1,2,3,4,5, dp_out=6'b001010, one scan_done_out on the sixth.
REQ-033 SHALL check: 15 or 17 sclk pulses then rclk -> frame_err pulse, outputs unchanged; frame 12 FE -> digit0_out=4'hE, seg_err; sel 8'hFC -> sel_err, no write.
REQ-034 SHALL check: coincident last sclk and rclk edges -> frame accepted; reset after 8 bits, then a 16-bit frame -> accepted correctly.
REQ-035 SHALL check: with TIMEOUT_CYCLES=100, no frames for 100 cycles -> stale_out=1; next valid frame -> stale_out=0; rejected frames alone keep stale_out=1.
